// File: rtl/lvds_rx_deframer_pkg.sv
// rtl/lvds_rx_deframer_pkg.sv - framing constants and state encodings shared by the LVDS RX deframer and TX framer
package lvds_rx_deframer_pkg;

    localparam int FRAME_PAIRS = 16;
    localparam int PHASE_W     = 4;

    localparam logic [1:0]  I_SYNC     = 2'b10;
    localparam logic [1:0]  Q_SYNC     = 2'b01;
    localparam logic [31:0] ZERO_FRAME = 32'h0000_0000;

    // The first pair is consumed on entry to SAMPLE, so the countdown starts two short
    localparam logic [PHASE_W-1:0] START_PHASE = PHASE_W'(FRAME_PAIRS - 2);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SAMPLE = 2'd1,
        CHECK  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/lvds_rx_deframer_sat_counter.sv
// rtl/lvds_rx_deframer_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lvds_rx_deframer.sv
// rtl/lvds_rx_deframer.sv - hunts frame sync on the 2-bit DDR LVDS link and pushes validated 32-bit I/Q words
module lvds_rx_deframer
    import lvds_rx_deframer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_ddr_clk,
    input  logic             i_rst_b,
    input  logic [1:0]       i_ddr_data,
    input  logic             i_fifo_full,
    output logic             o_fifo_write_clk,
    output logic             o_fifo_push,
    output logic [31:0]      o_fifo_data,
    input  logic             i_clear_counters,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_frame_err_cnt,
    output logic [CNT_W-1:0] o_overflow_cnt
);

    rx_state_t          state, state_n;
    logic [PHASE_W-1:0] phase, phase_n;
    logic [29:0]        shift, shift_n;
    logic               push_n;
    logic [31:0]        data_n;
    logic               locked_n;
    logic               frame_err_inc;
    logic               overflow_inc;
    logic [31:0]        word;

    assign o_fifo_write_clk = i_ddr_clk;
    assign word             = {shift, i_ddr_data};

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state       <= HUNT;
            phase       <= '0;
            shift       <= '0;
            o_fifo_push <= 1'b0;
            o_fifo_data <= ZERO_FRAME;
            o_locked    <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            shift       <= shift_n;
            o_fifo_push <= push_n;
            o_fifo_data <= data_n;
            o_locked    <= locked_n;
        end
    end

    always_comb begin
        state_n       = state;
        phase_n       = phase;
        shift_n       = shift;
        push_n        = 1'b0;
        data_n        = o_fifo_data;
        locked_n      = o_locked;
        frame_err_inc = 1'b0;
        overflow_inc  = 1'b0;

        case (state)
            HUNT: begin
                if (i_ddr_data == I_SYNC) begin
                    shift_n = {28'd0, i_ddr_data};
                    phase_n = START_PHASE;
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                shift_n = {shift[27:0], i_ddr_data};
                phase_n = phase - 1'b1;
                if (phase == '0) begin
                    if (word[15:14] == Q_SYNC) begin
                        // Framing is good even when the FIFO is full, so lock tracking continues
                        if (i_fifo_full) begin
                            overflow_inc = 1'b1;
                        end else begin
                            push_n = 1'b1;
                            data_n = word;
                        end
                        state_n = CHECK;
                    end else begin
                        frame_err_inc = 1'b1;
                        locked_n      = 1'b0;
                        state_n       = HUNT;
                    end
                end
            end
            CHECK: begin
                if (i_ddr_data == I_SYNC) begin
                    locked_n = 1'b1;
                    shift_n  = {28'd0, i_ddr_data};
                    phase_n  = START_PHASE;
                    state_n  = SAMPLE;
                end else begin
                    locked_n = 1'b0;
                    state_n  = HUNT;
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_frame_err_cnt (
        .clk   (i_ddr_clk),
        .rst_b (i_rst_b),
        .clr   (i_clear_counters),
        .inc   (frame_err_inc),
        .count (o_frame_err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_overflow_cnt (
        .clk   (i_ddr_clk),
        .rst_b (i_rst_b),
        .clr   (i_clear_counters),
        .inc   (overflow_inc),
        .count (o_overflow_cnt)
    );

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// tb/tb_lvds_rx_deframer.sv - directed scoreboard bench for lvds_rx_deframer
module tb_lvds_rx_deframer;

    logic        i_ddr_clk = 1'b0;
    logic        i_rst_b = 1'b0;
    logic [1:0]  i_ddr_data = 2'b00;
    logic        i_fifo_full = 1'b0;
    logic        i_clear_counters = 1'b0;
    logic        o_fifo_write_clk;
    logic        o_fifo_push;
    logic [31:0] o_fifo_data;
    logic        o_locked;
    logic [7:0]  o_frame_err_cnt;
    logic [7:0]  o_overflow_cnt;

    typedef struct {
        int          cyc;
        logic [31:0] word;
        logic        locked;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 i_ddr_clk = ~i_ddr_clk;

    lvds_rx_deframer #(.CNT_W(8)) dut (
        .i_ddr_clk        (i_ddr_clk),
        .i_rst_b          (i_rst_b),
        .i_ddr_data       (i_ddr_data),
        .i_fifo_full      (i_fifo_full),
        .o_fifo_write_clk (o_fifo_write_clk),
        .o_fifo_push      (o_fifo_push),
        .o_fifo_data      (o_fifo_data),
        .i_clear_counters (i_clear_counters),
        .o_locked         (o_locked),
        .o_frame_err_cnt  (o_frame_err_cnt),
        .o_overflow_cnt   (o_overflow_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Drive one pair, let the DUT clock it, then score the registered outputs
    task automatic step(input logic [1:0] p);
        exp_t e;
        i_ddr_data = p;
        @(posedge i_ddr_clk);
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("push", {31'd0, o_fifo_push}, 32'd1);
            chk("push_data", o_fifo_data, e.word);
            chk("push_locked", {31'd0, o_locked}, {31'd0, e.locked});
        end else begin
            chk("no_push", {31'd0, o_fifo_push}, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00);
    endtask

    task automatic send_frame(input logic [31:0] w, input bit exp_push, input logic exp_locked);
        exp_t e;
        if (exp_push) begin
            e.cyc    = cyc + 16;
            e.word   = w;
            e.locked = exp_locked;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 16; i++) step(w[31-2*i -: 2]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [13:0] iv, qv;
        iv = 14'($urandom);
        qv = 14'($urandom);
        return {2'b10, iv, 2'b01, qv};
    endfunction

    initial begin
        #1;
        chk("rst_push", {31'd0, o_fifo_push}, 32'd0);
        chk("rst_data", o_fifo_data, 32'd0);
        chk("rst_locked", {31'd0, o_locked}, 32'd0);
        chk("rst_err_cnt", {24'd0, o_frame_err_cnt}, 32'd0);
        chk("rst_ovf_cnt", {24'd0, o_overflow_cnt}, 32'd0);
        idle(3);
        i_rst_b = 1'b1;

        idle(64);
        chk("idle_locked", {31'd0, o_locked}, 32'd0);
        chk("idle_err_cnt", {24'd0, o_frame_err_cnt}, 32'd0);
        chk("idle_ovf_cnt", {24'd0, o_overflow_cnt}, 32'd0);

        send_frame(32'h8003_4048, 1'b1, 1'b0);
        idle(4);
        chk("single_locked", {31'd0, o_locked}, 32'd0);
        chk("single_hold_data", o_fifo_data, 32'h8003_4048);

        send_frame(rand_word(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_frame(rand_word(), 1'b1, 1'b1);
        chk("burst_locked_end", {31'd0, o_locked}, 32'd1);
        idle(4);
        chk("burst_unlock", {31'd0, o_locked}, 32'd0);

        send_frame(32'h8000_C000, 1'b0, 1'b0);
        chk("bad_err_cnt", {24'd0, o_frame_err_cnt}, 32'd1);
        send_frame(32'h9234_5678, 1'b1, 1'b0);
        idle(3);

        i_fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(rand_word(), 1'b0, 1'b0);
        i_fifo_full = 1'b0;
        idle(2);
        chk("ovf_cnt", {24'd0, o_overflow_cnt}, 32'd3);
        chk("ovf_err_cnt", {24'd0, o_frame_err_cnt}, 32'd1);
        i_clear_counters = 1'b1;
        step(2'b00);
        i_clear_counters = 1'b0;
        chk("clr_ovf_cnt", {24'd0, o_overflow_cnt}, 32'd0);
        chk("clr_err_cnt", {24'd0, o_frame_err_cnt}, 32'd0);

        for (int i = 0; i < 260; i++) send_frame(32'h8000_C000, 1'b0, 1'b0);
        chk("sat_err_cnt", {24'd0, o_frame_err_cnt}, 32'd255);
        i_clear_counters = 1'b1;
        send_frame(32'h8000_C000, 1'b0, 1'b0);
        i_clear_counters = 1'b0;
        chk("clr_wins_err_cnt", {24'd0, o_frame_err_cnt}, 32'd0);

        idle(2);
        send_frame(32'h8000_0000, 1'b0, 1'b0);
        send_frame(32'hA5A5_5A5A, 1'b1, 1'b0);
        chk("false_lock_err_cnt", {24'd0, o_frame_err_cnt}, 32'd1);
        idle(2);

        begin
            logic [31:0] w;
            w = 32'hBEEF_4321;
            for (int i = 0; i < 7; i++) step(w[31-2*i -: 2]);
        end
        i_rst_b = 1'b0;
        #1;
        chk("midrst_push", {31'd0, o_fifo_push}, 32'd0);
        chk("midrst_data", o_fifo_data, 32'd0);
        chk("midrst_locked", {31'd0, o_locked}, 32'd0);
        chk("midrst_err_cnt", {24'd0, o_frame_err_cnt}, 32'd0);
        idle(20);
        i_rst_b = 1'b1;
        idle(2);
        send_frame(32'hBEEF_4321, 1'b1, 1'b0);
        idle(3);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
